ram_dp_clr: RTL
===============

Name: ram_dp_clr

Overview:
- Parametrised synchronous simple-dual-port RAM: one write port and one read port, both on one clock.
- Separate data-in and data-out buses replace the shared tri-state data bus.
- Built-in clear engine sweeps every location to a fixed value after reset or on request, with a busy indication.
- Used as a generic scratch/buffer memory by datapath blocks that need a known memory state without a software init loop.

Parameters:
- DATA_W, 8, data word width in bits
- ADDR_W, 10, address width in bits
- DEPTH, 1024, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
- RD_MODE, 0, same-address read/write collision: 0 = read returns old data, 1 = read returns new (write-through) data
- CLR_VAL, 0, DATA_W-bit value written to every word by the clear engine

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous active-high reset
- cs  input  1  chip select; qualifies wr and rd
- wr  input  1  write request
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- rd  input  1  read request
- rd_addr  input  ADDR_W  read address
- rd_data  output  DATA_W  registered read data
- rd_valid  output  1  one-cycle pulse; rd_data is updated this cycle
- clr  input  1  one-cycle clear request
- busy  output  1  clear engine active; all accesses ignored
- err  output  1  one-cycle pulse; a request was dropped

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, rst.
- Reset values (rst high at an edge): state=CLEAR, clear pointer=0, busy=1, rd_data=0, rd_valid=0, err=0. No memory writes occur while rst is high.
- Memory contents are not reset directly; only the clear sweep initialises them.
- States: CLEAR and IDLE.
- CLEAR:
  - Each cycle with rst low, write CLR_VAL to mem[ptr], then ptr <= ptr+1.
  - In the cycle that writes mem[DEPTH-1], next state is IDLE.
  - busy is 0 from the following edge. busy therefore falls exactly DEPTH cycles after rst is first sampled low.
- IDLE, accepted write: cs & wr & (wr_addr < DEPTH). mem[wr_addr] <= wr_data at the edge.
- IDLE, accepted read: cs & rd & (rd_addr < DEPTH).
  - rd_data <= mem[rd_addr] at the edge and rd_valid=1 for that one cycle.
  - Latency is 1 clock.
  - rd_data holds its last value when no read is accepted.
  - rd_valid=0 otherwise.
- Read and write may both be accepted in the same cycle, at any addresses.
- Collision (both accepted, rd_addr==wr_addr):
  - RD_MODE=0: rd_data gets the pre-write content.
  - RD_MODE=1: rd_data gets wr_data.
  - The write always completes.
- Out-of-range address (>= DEPTH), only possible when DEPTH < 2**ADDR_W:
  - The request is ignored: no write, no rd_valid.
  - err pulses.
- Access while busy: any cs&wr or cs&rd is ignored and err pulses. rd_valid stays 0.
- clr in IDLE:
  - Next state is CLEAR with ptr=0 and busy=1 from the next edge.
  - Any access presented in the same cycle as clr is dropped and err pulses.
- clr in CLEAR restarts the sweep: ptr <= 0. busy falls DEPTH cycles after the last clr.
- rst mid-sweep or mid-operation returns to the reset state, and the sweep restarts after release.
- rst has priority over clr; clr has priority over accesses.
- err is registered; it pulses once per cycle regardless of how many requests that cycle dropped.

Test Plan:
- Reset sweep (DEPTH=16, CLR_VAL=8'hA5): rst high 3 cycles then low -> busy=1 for exactly 16 cycles. Afterwards, reads of addresses 0..15 each return 8'hA5 with rd_valid one cycle after the request.
- Basic write/read: write 8'h3C to addr 5, then read addr 5 next cycle -> rd_data=8'h3C with rd_valid=1 one cycle after the read. rd_data holds 8'h3C when rd=0.
- Collision: mem[7]=8'h11; simultaneous write 8'h22 and read at addr 7 -> rd_data=8'h11 with RD_MODE=0, 8'h22 with RD_MODE=1. A following read returns 8'h22 in both modes.
- Clear mid-operation: after writes, pulse clr, then re-pulse clr 5 cycles into the sweep -> busy stays high 16 cycles after the second clr. All locations read CLR_VAL afterwards.
- Dropped accesses: write addr 3 while busy -> err=1 for one cycle, mem[3] unchanged. Read while busy -> rd_valid=0 and err=1.
- Out of range (ADDR_W=5, DEPTH=20): write addr 25 -> err pulse and no memory change. Read addr 25 -> no rd_valid, err pulse.

Source files
------------

// File: rtl/ram_dp_clr.sv
// Simple-dual-port synchronous RAM with one write port, one registered read port and a
// built-in clear engine that sweeps every word to CLR_VAL after reset or on request.
module ram_dp_clr #(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       ADDR_W  = 10,
  parameter int unsigned       DEPTH   = 1024,
  parameter int unsigned       RD_MODE = 0,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr,
  output logic              busy,
  output logic              err
);

  localparam int unsigned       IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

  typedef enum logic {StClear, StIdle} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              err_q;

  logic              wr_req, rd_req;
  logic              wr_in_range, rd_in_range;
  logic              wr_acc, rd_acc;
  logic              collide;
  logic              err_d;
  logic              mem_we;
  logic [IdxW-1:0]   mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [IdxW-1:0]   rd_idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: clr restarts the sweep from either state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (clr) begin
      state_d = StClear;
      ptr_d   = '0;
    end else if (state_q == StClear) begin
      if (ptr_q == LastPtr) begin
        state_d = StIdle;
        ptr_d   = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  // Outputs and access qualification
  always_comb begin
    busy        = (state_q == StClear);
    wr_req      = cs & wr;
    rd_req      = cs & rd;
    wr_in_range = ({1'b0, wr_addr} < DepthW);
    rd_in_range = ({1'b0, rd_addr} < DepthW);
    wr_acc      = ~busy & ~clr & wr_req & wr_in_range;
    rd_acc      = ~busy & ~clr & rd_req & rd_in_range;
    collide     = wr_acc & (wr_addr == rd_addr);
    // Any request that was not accepted counts as dropped
    err_d       = (wr_req & ~wr_acc) | (rd_req & ~rd_acc);
    mem_we      = busy | wr_acc;
    mem_waddr   = busy ? ptr_q[IdxW-1:0] : wr_addr[IdxW-1:0];
    mem_wdata   = busy ? CLR_VAL : wr_data;
    rd_idx      = rd_addr[IdxW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      err_q      <= err_d;
      if (rd_acc) begin
        // The non-blocking memory write leaves mem[] holding pre-write data here
        rd_data_q <= ((RD_MODE != 0) && collide) ? wr_data : mem[rd_idx];
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;

endmodule
